dot8_acc: RTL



---
 rtl/dot8_acc_pkg.sv | 7 +
 rtl/dot8_acc_arith.sv | 19 +
 rtl/dot8_acc.sv | 67 ++++++
 3 files changed

// File: rtl/dot8_acc_pkg.sv
// dot8_acc_pkg: shared FSM encoding and default sizing for the dot-product accumulator.
package dot8_acc_pkg;
  localparam logic S_ACC = 1'b0;
  localparam logic S_OUT = 1'b1;
  localparam int ACC_W_DEF = 20;
  localparam int LEN_DEF = 4;
endpackage

// File: rtl/dot8_acc_arith.sv
// dot8_acc_arith: 8x8 natural multiplier and N-bit adder used by the accumulator.
module mul8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = 16'(a) * 16'(b);
endmodule

module add #(
  parameter int N = 21
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s
);
  assign s = a + b + N'(c_in);
endmodule

// File: rtl/dot8_acc.sv
// dot8_acc: accumulates LEN products of 8-bit pairs and presents the sum on a valid/ready port.
module dot8_acc
  import dot8_acc_pkg::*;
#(
  parameter int LEN = LEN_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic             state;
  logic [ACC_W-1:0] acc;
  logic             acc_ovf;
  logic [7:0]       cnt;
  logic [15:0]      p;
  logic [ACC_W:0]   s;
  logic             accept;
  logic             last;
  mul8 u_mul (.a(x), .b(y), .p(p));
  // bit ACC_W of the widened sum is the carry out of the accumulator
  add #(.N(ACC_W + 1)) u_add (
    .a   ({1'b0, acc}),
    .b   ({{(ACC_W + 1 - 16){1'b0}}, p}),
    .c_in(1'b0),
    .s   (s)
  );
  assign in_ready = (state == S_ACC) | out_ready;
  assign accept = in_valid & in_ready;
  assign last = cnt == 8'(LEN - 1);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_ACC;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (state == S_OUT && out_ready) begin
        out_valid <= 1'b0;
        state     <= S_ACC;
      end
      if (accept && last) begin
        sum       <= s[ACC_W-1:0];
        ovf       <= acc_ovf | s[ACC_W];
        out_valid <= 1'b1;
        acc       <= '0;
        acc_ovf   <= 1'b0;
        cnt       <= '0;
        state     <= S_OUT;
      end else if (accept) begin
        acc     <= s[ACC_W-1:0];
        acc_ovf <= acc_ovf | s[ACC_W];
        cnt     <= cnt + 8'd1;
      end
    end
  end
endmodule
